// File: rtl/elm_pkg.sv
// Shared constants and FSM state encoding for the ELM hidden-layer MAC engine.
package elm_pkg;

  localparam int unsigned N_IN  = 784;
  localparam int unsigned N_HID = 64;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned W_W   = 16;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned SHIFT = 12;
  localparam int unsigned OUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_ACT,
    ST_OUT
  } hmac_state_t;

endpackage

// File: rtl/elm_sat_shift.sv
// Arithmetic right shift of the accumulator followed by saturation to OUT_W bits.
// HMAC_RELU_EN: clamp negative results to zero (ReLU); otherwise linear activation.
module elm_sat_shift #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SHIFT = 12,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_act
);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_s;

  assign w_s = i_acc >>> SHIFT;

  always_comb begin
    if (w_s > MAXV) begin
      o_act = MAXV[OUT_W-1:0];
    end else if (w_s < MINV) begin
      o_act = MINV[OUT_W-1:0];
    end else begin
      o_act = w_s[OUT_W-1:0];
    end
`ifdef HMAC_RELU_EN
    if (w_s[ACC_W-1]) begin
      o_act = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/elm_hidden_mac.sv
// ELM hidden-layer MAC: streams N_IN pixels x generator weights per neuron, then scales,
// saturates and activates each sum. Optional ReLU activation via HMAC_RELU_EN.
module elm_hidden_mac #(
  parameter int unsigned N_IN  = elm_pkg::N_IN,
  parameter int unsigned N_HID = elm_pkg::N_HID,
  parameter int unsigned PIX_W = elm_pkg::PIX_W,
  parameter int unsigned W_W   = elm_pkg::W_W,
  parameter int unsigned ACC_W = elm_pkg::ACC_W,
  parameter int unsigned SHIFT = elm_pkg::SHIFT,
  parameter int unsigned OUT_W = elm_pkg::OUT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       pix_valid,
  input  logic [PIX_W-1:0]           pix_data,
  output logic                       pix_ready,
  input  logic signed [W_W-1:0]      wgt_data,
  output logic                       wgt_adv,
  output logic                       h_valid,
  output logic signed [OUT_W-1:0]    h_data,
  output logic [$clog2(N_HID)-1:0]   h_idx,
  input  logic                       h_ready,
  output logic                       busy,
  output logic                       done
);

  import elm_pkg::*;

  localparam int unsigned HIDX_W = $clog2(N_HID);
  localparam int unsigned CNT_W  = $clog2(N_IN);
  localparam int unsigned PRD_W  = PIX_W + W_W + 1;

  if (ACC_W < PIX_W + W_W + $clog2(N_IN) + 1) begin : g_acc_w_chk
    $error("elm_hidden_mac: ACC_W too narrow for N_IN products");
  end

  hmac_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]         r_cnt;
  logic [HIDX_W-1:0]        r_h_idx;
  logic signed [PRD_W-1:0]  r_prod;
  logic                     r_prod_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [OUT_W-1:0]  r_h_data;
  logic                     r_done;

  logic                     w_accept;
  logic                     w_last_pix;
  logic                     w_hs;
  logic                     w_last_neuron;
  logic signed [PRD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [OUT_W-1:0]  w_act;

  assign pix_ready     = (r_state == ST_ACC);
  assign w_accept      = pix_ready & pix_valid;
  assign wgt_adv       = w_accept;
  assign w_last_pix    = (r_cnt == CNT_W'(N_IN - 1));
  assign h_valid       = (r_state == ST_OUT);
  assign w_hs          = h_valid & h_ready;
  assign w_last_neuron = (r_h_idx == HIDX_W'(N_HID - 1));
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign h_data        = r_h_data;
  assign h_idx         = r_h_idx;

  // Pixel is zero-extended so the product stays a signed multiply.
  assign w_prod     = $signed({1'b0, pix_data}) * $signed(wgt_data);
  assign w_prod_ext = {{(ACC_W-PRD_W){r_prod[PRD_W-1]}}, r_prod};

  elm_sat_shift #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_acc (r_acc),
    .o_act (w_act)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ACC;
      ST_ACC:   if (w_accept && w_last_pix) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_ACT;
      ST_ACT:   w_state_nxt = ST_OUT;
      ST_OUT:   if (w_hs) w_state_nxt = w_last_neuron ? ST_IDLE : ST_ACC;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The stage-2 add only fires in ACC/DRAIN, so the clears below never collide with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_h_idx    <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_h_data   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_prod_vld <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
      end
      if (r_prod_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
      r_done <= w_hs & w_last_neuron;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_h_idx <= '0;
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACT: begin
          r_h_data <= w_act;
        end
        ST_OUT: begin
          if (w_hs && !w_last_neuron) begin
            r_h_idx <= r_h_idx + 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
